crc32_8bit_parallel_frame_checker: RTL and testbench



---
 rtl/crc32_8bit_parallel_frame_checker.sv | 107 ++++++++++
 tb/tb_crc32_8bit_parallel_frame_checker.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/crc32_8bit_parallel_frame_checker.sv
// crc32_8bit_parallel_frame_checker: CRC-32 residue check, FCS strip and per-frame status; err_cnt when CRC32_FRAME_CHK_ERR_CNT_EN is defined
module crc32_8bit_parallel_frame_checker #(
  parameter logic [31:0] RESET_SEED = 32'h0000_0000,
  parameter int MIN_FRAME_LEN = 5,
  parameter int MAX_FRAME_LEN = 1518
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  input  logic        clear,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [15:0] frame_len,
  output logic        frame_abort
`ifdef CRC32_FRAME_CHK_ERR_CNT_EN
  ,
  output logic [15:0] err_cnt
`endif
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN = 1'b1;
  localparam logic [31:0] POLY = 32'h04C1_1DB7;
  localparam logic [15:0] MIN_L = 16'(MIN_FRAME_LEN);
  localparam logic [15:0] MAX_L = 16'(MAX_FRAME_LEN);
  logic [0:0] state;
  logic [31:0] crc, crc_n;
  logic [3:0][7:0] dl;
  logic [2:0] fill;
  logic [15:0] len, len_n;
  logic ok_n;
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) r = {r[30:0], 1'b0} ^ ((r[31] ^ d[i]) ? POLY : 32'h0);
    return r;
  endfunction
  // next CRC, saturating length and the pass verdict for a byte arriving this cycle
  always_comb begin
    crc_n = crc_byte(crc, s_data);
    len_n = (len == 16'hFFFF) ? len : len + 16'd1;
    ok_n = (crc_n == 32'h0) && (len_n != 16'hFFFF) && (len_n >= MIN_L) && (len_n <= MAX_L);
  end
  // frame state, delay line, status pulses; clear beats a same-cycle byte
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      crc <= RESET_SEED;
      dl <= '0;
      fill <= '0;
      len <= '0;
      m_data <= '0;
      m_valid <= 1'b0;
      m_last <= 1'b0;
      frame_done <= 1'b0;
      frame_ok <= 1'b0;
      frame_len <= '0;
      frame_abort <= 1'b0;
    end else begin
      m_valid <= 1'b0;
      m_last <= 1'b0;
      frame_done <= 1'b0;
      frame_abort <= 1'b0;
      if (clear) begin
        if (state == RUN) begin
          state <= IDLE;
          crc <= RESET_SEED;
          fill <= '0;
          len <= '0;
          frame_abort <= 1'b1;
        end
      end else if (s_valid) begin
        dl <= {dl[2:0], s_data};
        if (fill == 3'd4) begin
          m_data <= dl[3];
          m_valid <= 1'b1;
          m_last <= s_last;
        end
        if (s_last) begin
          state <= IDLE;
          crc <= RESET_SEED;
          fill <= '0;
          len <= '0;
          frame_done <= 1'b1;
          frame_ok <= ok_n;
          frame_len <= len_n;
        end else begin
          state <= RUN;
          crc <= crc_n;
          fill <= (fill == 3'd4) ? fill : fill + 3'd1;
          len <= len_n;
        end
      end
    end
  end
`ifdef CRC32_FRAME_CHK_ERR_CNT_EN
  // saturating count of completed frames that failed
  always_ff @(posedge CLK) begin
    if (RST) err_cnt <= '0;
    else if (!clear && s_valid && s_last && !ok_n && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_crc32_8bit_parallel_frame_checker.sv
// tb_crc32_8bit_parallel_frame_checker: random and directed frames against a queue-based reference
module tb_crc32_8bit_parallel_frame_checker;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [7:0] s_data = '0;
  logic s_valid = 1'b0, s_last = 1'b0, clear = 1'b0;
  logic [7:0] m_data;
  logic m_valid, m_last, frame_done, frame_ok, frame_abort;
  logic [15:0] frame_len;
`ifdef CRC32_FRAME_CHK_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif
  int checks = 0, failures = 0;
  logic [8:0] exp_data[$];
  logic [16:0] exp_stat[$];
  int exp_abort = 0;
  int exp_err = 0;
  logic [7:0] fr[$];

  crc32_8bit_parallel_frame_checker dut (
    .CLK(CLK), .RST(RST), .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .clear(clear),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .frame_done(frame_done),
    .frame_ok(frame_ok), .frame_len(frame_len), .frame_abort(frame_abort)
`ifdef CRC32_FRAME_CHK_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // message polynomial remainder: the whole frame as one MSB-first bit stream through the divisor
  function automatic logic [31:0] crc_ref(input logic [7:0] b[$]);
    logic [31:0] r = 32'h0;
    logic bit_in;
    foreach (b[k])
      for (int j = 7; j >= 0; j--) begin
        bit_in = b[k][j];
        r = {r[30:0], 1'b0} ^ ((r[31] ^ bit_in) ? 32'h04C1_1DB7 : 32'h0);
      end
    return r;
  endfunction

  task automatic put(input logic v, input logic [7:0] d, input logic l, input logic c);
    @(negedge CLK);
    s_valid = v; s_data = d; s_last = l; clear = c;
  endtask

  task automatic idle(input int n);
    repeat (n) put(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic make_good(input int plen);
    logic [31:0] c;
    fr.delete();
    repeat (plen) fr.push_back(8'($urandom));
    c = crc_ref(fr);
    fr.push_back(c[31:24]); fr.push_back(c[23:16]); fr.push_back(c[15:8]); fr.push_back(c[7:0]);
  endtask

  task automatic send(input int gap);
    int n = fr.size();
    logic ok = (crc_ref(fr) == 32'h0) && n >= 5 && n <= 1518;
    exp_stat.push_back({ok, 16'(n)});
    for (int i = 0; i < n - 4; i++) exp_data.push_back({i == n - 5, fr[i]});
    for (int i = 0; i < n; i++) begin
      put(1'b1, fr[i], i == n - 1, 1'b0);
      if (i != n - 1) idle(gap);
    end
  endtask

  task automatic rst_check(input string tag);
    put(1'b0, 8'h00, 1'b0, 1'b0);
    RST = 1'b1;
    @(negedge CLK);
    check(tag, {m_data, m_valid, m_last, frame_done, frame_ok, frame_abort, frame_len}, 32'h0);
`ifdef CRC32_FRAME_CHK_ERR_CNT_EN
    check({tag, "_err"}, 32'(err_cnt), 32'h0);
`endif
    exp_err = 0;
    RST = 1'b0;
  endtask

  // scoreboard: every output event must match the next expectation
  always @(negedge CLK) begin
    logic [8:0] e;
    logic [16:0] s;
    if (!RST) begin
      if (m_valid) begin
        if (exp_data.size() == 0) check("m_valid_unexpected", 32'(m_valid), 32'h0);
        else begin
          e = exp_data.pop_front();
          check("m_data", 32'(m_data), 32'(e[7:0]));
          check("m_last", 32'(m_last), 32'(e[8]));
        end
      end else if (m_last) check("m_last_without_valid", 32'(m_last), 32'h0);
      if (frame_done) begin
        if (exp_stat.size() == 0) check("frame_done_unexpected", 32'(frame_done), 32'h0);
        else begin
          s = exp_stat.pop_front();
          check("frame_ok", 32'(frame_ok), 32'(s[16]));
          check("frame_len", 32'(frame_len), 32'(s[15:0]));
          if (!s[16]) exp_err++;
`ifdef CRC32_FRAME_CHK_ERR_CNT_EN
          check("err_cnt", 32'(err_cnt), 32'(exp_err));
`endif
        end
      end
      if (frame_abort) begin
        check("frame_abort_expected", 32'(exp_abort != 0), 32'h1);
        if (exp_abort > 0) exp_abort--;
      end
    end
  end

  initial begin
    logic [31:0] tmp;
    repeat (2) @(negedge CLK);
    check("reset_outs", {m_data, m_valid, m_last, frame_done, frame_ok, frame_abort, frame_len}, 32'h0);
    RST = 1'b0;
    fr = '{8'h01};
    check("ref_model_anchor", crc_ref(fr), 32'h04C1_1DB7);
    fr = '{8'h01, 8'h04, 8'hC1, 8'h1D, 8'hB7};
    send(0); idle(2);
    fr = '{8'h01, 8'h04, 8'hC1, 8'h1D, 8'hB6};
    send(0); idle(2);
    fr = '{8'h01, 8'h04, 8'hC1, 8'h1D, 8'hB7};
    send(3);
    make_good(3);
    send(0); idle(2);
    fr = '{8'hAA, 8'hBB, 8'hCC};
    send(0); idle(2);
    fr = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    exp_data.push_back({1'b0, 8'h11});
    exp_data.push_back({1'b0, 8'h22});
    foreach (fr[i]) put(1'b1, fr[i], 1'b0, 1'b0);
    exp_abort++;
    put(1'b1, 8'h77, 1'b0, 1'b1);
    idle(2);
    fr = '{8'h01, 8'h04, 8'hC1, 8'h1D, 8'hB7};
    send(0); idle(2);
    put(1'b1, 8'h9A, 1'b0, 1'b0);
    put(1'b1, 8'hBC, 1'b0, 1'b0);
    put(1'b1, 8'hDE, 1'b0, 1'b0);
    rst_check("rst_mid_frame");
    make_good(2);
    send(1); idle(2);
    for (int f = 0; f < 30; f++) begin
      if ($urandom_range(4, 0) == 0) begin
        fr.delete();
        repeat ($urandom_range(4, 1)) fr.push_back(8'($urandom));
      end else begin
        make_good($urandom_range(12, 1));
        if ($urandom_range(3, 0) == 0) begin
          tmp = $urandom_range(fr.size() - 1, 0);
          fr[tmp] = fr[tmp] ^ 8'(1 << $urandom_range(7, 0));
        end
      end
      send($urandom_range(2, 0));
      idle($urandom_range(2, 0));
    end
    idle(6);
    check("pending_data", 32'(exp_data.size()), 32'h0);
    check("pending_status", 32'(exp_stat.size()), 32'h0);
    check("pending_abort", 32'(exp_abort), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
